avg_decimator: RTL and testbench

- Multi-channel, parametrised decimator for the ADC output path.
- Per channel, accepts one DATA_W-bit sample per valid cycle and emits one result every 2^k accepted samples.
- Mode select: sample-and-hold (last sample) or boxcar average (accumulate-and-dump with shift).
- Output register uses a valid/ready handshake with sticky overrun detection; downstream is a FIFO or serialiser.

---
 rtl/avg_decimator.sv | 90 +++++++++
 tb/tb_avg_decimator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avg_decimator.sv
// Multi-channel decimator for the ADC output path: sample-and-hold or boxcar
// average over 2^k accepted samples, with a valid/ready output register and sticky overrun.
module avg_decimator #(
  parameter int DATA_W   = 12,
  parameter int CH       = 2,
  parameter int LOG2_MAX = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [CH*DATA_W-1:0] data_in,
  input  logic [3:0]           log2_ratio,
  input  logic                 mode,
  input  logic                 out_ready,
  input  logic                 clr_overrun,
  output logic [CH*DATA_W-1:0] data_out,
  output logic                 out_valid,
  output logic                 overrun
);

  localparam int ACC_W = DATA_W + LOG2_MAX;
  localparam logic [LOG2_MAX:0]   RATIO_ONE = 1;
  localparam logic [LOG2_MAX-1:0] CNT_ONE   = 1;

  logic [LOG2_MAX-1:0] cnt;
  logic [3:0]          k_q;
  logic [3:0]          k_in;
  logic [3:0]          k_eff;
  logic                mode_q;
  logic                mode_eff;
  logic                first;
  logic                frame_end;
  logic                load_out;
  logic                ovr_event;
  logic [LOG2_MAX:0]   ratio;
  logic [ACC_W-1:0]    acc [CH];
  logic [ACC_W-1:0]    sum [CH];
  logic [CH*DATA_W-1:0] result;

  // The first sample of a frame sees the live config; later samples use the latched copy.
  always_comb begin
    k_in      = (log2_ratio > 4'(LOG2_MAX)) ? 4'(LOG2_MAX) : log2_ratio;
    first     = (cnt == '0);
    k_eff     = first ? k_in : k_q;
    mode_eff  = first ? mode : mode_q;
    ratio     = RATIO_ONE << k_eff;
    frame_end = in_valid && (cnt == LOG2_MAX'(ratio - RATIO_ONE));
    load_out  = frame_end && (!out_valid || out_ready);
    ovr_event = frame_end && out_valid && !out_ready;
    result    = '0;
    for (int c = 0; c < CH; c++) begin
      sum[c] = (first ? '0 : acc[c]) + ACC_W'(data_in[c*DATA_W +: DATA_W]);
      result[c*DATA_W +: DATA_W] = mode_eff ? DATA_W'(sum[c] >> k_eff)
                                            : data_in[c*DATA_W +: DATA_W];
    end
  end

  // Output handshake: data_out is transferred on any cycle with out_valid && out_ready.
  // out_valid stays high until that transfer; a frame result that finds the register
  // still occupied and not being drained is dropped and flagged via overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      k_q       <= '0;
      mode_q    <= 1'b0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int c = 0; c < CH; c++) acc[c] <= '0;
    end else begin
      if (in_valid) begin
        if (first) begin
          k_q    <= k_in;
          mode_q <= mode;
        end
        cnt <= frame_end ? '0 : cnt + CNT_ONE;
        for (int c = 0; c < CH; c++) acc[c] <= sum[c];
      end
      if (load_out) begin
        data_out  <= result;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (ovr_event) overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_avg_decimator.sv
// Bench for avg_decimator: directed scenarios plus random traffic, checked against a
// frame-level reference model feeding an expected-result queue.
module tb_avg_decimator;

  localparam int DW = 12;
  localparam int NCH = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [NCH*DW-1:0] data_in = '0;
  logic [3:0]        log2_ratio = '0;
  logic              mode = 1'b0;
  logic              out_ready = 1'b0;
  logic              clr_overrun = 1'b0;
  logic [NCH*DW-1:0] data_out;
  logic              out_valid;
  logic              overrun;

  avg_decimator #(.DATA_W(DW), .CH(NCH), .LOG2_MAX(9)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .log2_ratio(log2_ratio), .mode(mode), .out_ready(out_ready),
    .clr_overrun(clr_overrun), .data_out(data_out), .out_valid(out_valid),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  logic [NCH*DW-1:0] exp_q[$];

  int s0_q[$];
  int s1_q[$];
  int lat_k = 0;
  bit lat_mode = 1'b0;
  bit mod_valid = 1'b0;
  bit mod_ovr = 1'b0;
  bit model_init = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Frame-level model: collect the frame's samples, then take the last one or the
  // truncated mean once 2^k of them have arrived.
  function automatic void model_update();
    bit got_res;
    bit ovr_ev;
    int a0;
    int a1;
    logic [NCH*DW-1:0] res;
    if (rst) begin
      s0_q.delete();
      s1_q.delete();
      exp_q.delete();
      mod_valid = 1'b0;
      mod_ovr = 1'b0;
      model_init = 1'b1;
      return;
    end
    got_res = 1'b0;
    res = '0;
    if (in_valid) begin
      if (s0_q.size() == 0) begin
        lat_k = (int'(log2_ratio) > 9) ? 9 : int'(log2_ratio);
        lat_mode = mode;
      end
      s0_q.push_back(int'(data_in[DW-1:0]));
      s1_q.push_back(int'(data_in[2*DW-1:DW]));
      if (s0_q.size() == (1 << lat_k)) begin
        if (lat_mode) begin
          a0 = 0;
          a1 = 0;
          foreach (s0_q[i]) begin
            a0 += s0_q[i];
            a1 += s1_q[i];
          end
          a0 = a0 / (1 << lat_k);
          a1 = a1 / (1 << lat_k);
        end else begin
          a0 = s0_q[s0_q.size()-1];
          a1 = s1_q[s1_q.size()-1];
        end
        res = {a1[DW-1:0], a0[DW-1:0]};
        got_res = 1'b1;
        s0_q.delete();
        s1_q.delete();
      end
    end
    ovr_ev = got_res && mod_valid && !out_ready;
    if (got_res && !ovr_ev) begin
      exp_q.push_back(res);
      mod_valid = 1'b1;
    end else if (mod_valid && out_ready) begin
      mod_valid = 1'b0;
    end
    if (ovr_ev) mod_ovr = 1'b1;
    else if (clr_overrun) mod_ovr = 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic drive(input bit iv, input int d0, input int d1, input int lr,
                       input bit m, input bit rdy, input bit clr);
    rst = 1'b0;
    in_valid = iv;
    data_in = {DW'(d1), DW'(d0)};
    log2_ratio = 4'(lr);
    mode = m;
    out_ready = rdy;
    clr_overrun = clr;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'($urandom_range(0, 1));
    data_in = NCH*DW'($urandom);
    out_ready = 1'($urandom_range(0, 1));
    clr_overrun = 1'b0;
    tick();
    rst = 1'b0;
    chk("reset_data_out", 32'(data_out), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
  endtask

  // Monitor: flags against the model every cycle, data popped on each transfer.
  always @(negedge clk) begin
    if (model_init) begin
      chk("out_valid_flag", 32'(out_valid), 32'(mod_valid));
      chk("overrun_flag", 32'(overrun), 32'(mod_ovr));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(data_out), 32'hffff_ffff);
        end else begin
          chk("scoreboard_data", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    do_reset();

    // Last-sample mode, ratio 512.
    for (int i = 0; i < 1024; i++) begin
      drive(1'b1, i, 4095 - i, 9, 1'b0, 1'b1, 1'b0);
      if (i == 510) chk("t1_no_early", 32'(out_valid), 32'd0);
      if (i == 511) chk("t1_first", 32'({out_valid, data_out}), 32'({1'b1, 12'd3584, 12'd511}));
      if (i == 512) chk("t1_drop_valid", 32'(out_valid), 32'd0);
      if (i == 1023) chk("t1_second", 32'({out_valid, data_out}), 32'({1'b1, 12'd3072, 12'd1023}));
    end

    // Averaging with truncation.
    do_reset();
    for (int i = 1; i <= 4; i++) drive(1'b1, i, 4095, 2, 1'b1, 1'b1, 1'b0);
    chk("t2_avg", 32'({out_valid, data_out}), 32'({1'b1, 12'd4095, 12'd2}));
    for (int i = 0; i < 4; i++) drive(1'b1, (i == 3) ? 3 : 0, 4095, 2, 1'b1, 1'b1, 1'b0);
    chk("t2_trunc", 32'({out_valid, data_out}), 32'({1'b1, 12'd4095, 12'd0}));

    // Gapped input.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) drive(1'b1, i / 2 + 1, 4095, 2, 1'b1, 1'b1, 1'b0);
      else drive(1'b0, int'($urandom_range(0, 4095)), 7, 2, 1'b1, 1'b1, 1'b0);
      if (i == 5) chk("t3_no_early", 32'(out_valid), 32'd0);
    end
    chk("t3_gapped", 32'({out_valid, data_out}), 32'({1'b1, 12'd4095, 12'd2}));

    // Backpressure, overrun, clear, then set-wins over clear.
    do_reset();
    drive(1'b1, 5, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("t4_load5", 32'({overrun, out_valid, data_out[DW-1:0]}), 32'({1'b0, 1'b1, 12'd5}));
    drive(1'b1, 6, 0, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 7, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("t4_hold5", 32'({overrun, out_valid, data_out[DW-1:0]}), 32'({1'b1, 1'b1, 12'd5}));
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    chk("t4_clr", 32'(overrun), 32'd0);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("t4_drained", 32'(out_valid), 32'd0);
    drive(1'b1, 8, 0, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9, 0, 0, 1'b0, 1'b0, 1'b1);
    chk("t4_set_wins", 32'({overrun, data_out[DW-1:0]}), 32'({1'b1, 12'd8}));
    drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1);

    // Frame end coinciding with a transfer.
    drive(1'b1, 10, 0, 0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 11, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("t5_simul", 32'({overrun, out_valid, data_out[DW-1:0]}), 32'({1'b0, 1'b1, 12'd11}));

    // Mid-frame ratio change.
    do_reset();
    drive(1'b1, 1, 0, 2, 1'b0, 1'b1, 1'b0);
    for (int i = 2; i <= 4; i++) drive(1'b1, i, 0, 3, 1'b0, 1'b1, 1'b0);
    chk("t6_end4", 32'({out_valid, data_out[DW-1:0]}), 32'({1'b1, 12'd4}));
    for (int i = 11; i <= 18; i++) begin
      drive(1'b1, i, 0, 3, 1'b0, 1'b1, 1'b0);
      if (i == 17) chk("t6_no_early8", 32'(out_valid), 32'd0);
    end
    chk("t6_end8", 32'({out_valid, data_out[DW-1:0]}), 32'({1'b1, 12'd18}));

    // Reset mid-frame.
    for (int i = 0; i < 3; i++) drive(1'b1, 50 + i, 0, 2, 1'b0, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 60 + i, 0, 2, 1'b0, 1'b1, 1'b0);
      if (i == 2) chk("t6_rst_no_early", 32'(out_valid), 32'd0);
    end
    chk("t6_rst_full", 32'({out_valid, data_out[DW-1:0]}), 32'({1'b1, 12'd63}));

    // Ratio clamp: 15 acts as 9.
    drive(1'b0, 0, 0, 15, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, 100, 200, 15, 1'b1, 1'b1, 1'b0);
      if (i == 510) chk("t6_clamp_no_early", 32'(out_valid), 32'd0);
    end
    chk("t6_clamp", 32'({out_valid, data_out}), 32'({1'b1, 12'd200, 12'd100}));

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        drive(1'($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
              ($urandom_range(0, 15) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 15) == 0));
      end
    end

    for (int i = 0; i < 3; i++) drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
